// File: rtl/perf_pkg.sv
// Shared definitions for the performance event monitor: FSM states and the
// fixed dump-index layout (cycles, instructions, then generic event channels).
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } perfState_t;

    localparam int IDX_CYCLES = 0;
    localparam int IDX_INSTS  = 1;
    localparam int IDX_EVT0   = 2;

endpackage

// File: rtl/perf_event_monitor_sat_counter.sv
// Saturating counter with a sticky overflow flag. The value holds at all-ones
// and an increment attempted there sets ovf until the next clear or reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic atMax;

    assign atMax = &cnt;

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples its inputs at the same edge, independent of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en && inc) begin
            if (atMax) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_event_monitor.sv
// Performance monitor: counts cycles, retired instructions and generic events
// while armed, freezes on halt and streams the counters over a valid/ready port.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  retire,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_vld,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [IDX_W-1:0]      dump_idx,
    output logic [CNT_W-1:0]      dump_data,
    output logic                  dump_last,
    output logic [NUM_EVENTS+1:0] ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_CNT = NUM_EVENTS + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

    perfState_t       state;
    perfState_t       nextState;
    logic [IDX_W-1:0] dumpPtr;
    logic [NUM_CNT-1:0] incVec;
    logic [CNT_W-1:0] cntArr [NUM_CNT];
    logic             countEn;
    logic             inDump;
    logic             atLast;
    logic             dumpFire;

    assign countEn  = (state == COUNT);
    assign inDump   = (state == DUMP);
    assign atLast   = (dumpPtr == LAST_IDX);
    assign dumpFire = inDump && dump_ready;

    always_comb begin
        incVec             = '0;
        incVec[IDX_CYCLES] = 1'b1;
        incVec[IDX_INSTS]  = retire;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            incVec[IDX_EVT0 + k] = event_vld[k];
        end
    end

    // The halt cycle is still in COUNT, so it is counted like any other cycle.
    for (genvar i = 0; i < NUM_CNT; i++) begin : gen_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clear),
            .en  (countEn),
            .inc (incVec[i]),
            .cnt (cntArr[i]),
            .ovf (ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: nextState gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = COUNT;
            COUNT:   if (halt) nextState = DUMP;
            DUMP:    if (dumpFire && atLast) nextState = DONE;
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
        if (clear) begin
            nextState = IDLE;
        end
    end

    // Pointer is parked at 0 outside DUMP so every dump begins with the cycle count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dumpPtr <= '0;
        end else if (clear || !inDump) begin
            dumpPtr <= '0;
        end else if (dumpFire) begin
            dumpPtr <= atLast ? '0 : dumpPtr + IDX_W'(1);
        end
    end

    always_comb begin
        dump_data = '0;
        if (inDump) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (dumpPtr == IDX_W'(i)) begin
                    dump_data = cntArr[i];
                end
            end
        end
    end

    assign dump_valid = inDump;
    assign dump_idx   = inDump ? dumpPtr : '0;
    assign dump_last  = inDump && atLast;
    assign busy       = (state == COUNT) || inDump;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor with an 8-bit counter build so
// saturation is reachable; expectations come from unbounded integer tallies.
module tb_perf_event_monitor;

    localparam int NUM_EVENTS = 4;
    localparam int CNT_W      = 8;
    localparam int IDX_W      = 5;
    localparam int NUM_CNT    = NUM_EVENTS + 2;
    localparam int MAXV       = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  clear;
    logic                  retire;
    logic                  halt;
    logic [NUM_EVENTS-1:0] event_vld;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [IDX_W-1:0]      dump_idx;
    logic [CNT_W-1:0]      dump_data;
    logic                  dump_last;
    logic [NUM_CNT-1:0]    ovf;
    logic                  busy;
    logic                  done;

    int nAssert = 0;
    int nFail   = 0;
    int refCnt[NUM_CNT];

    perf_event_monitor #(
        .NUM_EVENTS (NUM_EVENTS),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .retire     (retire),
        .halt       (halt),
        .event_vld  (event_vld),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .ovf        (ovf),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zeroModel();
        for (int i = 0; i < NUM_CNT; i++) refCnt[i] = 0;
    endtask

    function automatic logic [CNT_W-1:0] expData(input int i);
        return (refCnt[i] > MAXV) ? CNT_W'(MAXV) : CNT_W'(refCnt[i]);
    endfunction

    function automatic logic [NUM_CNT-1:0] expOvf();
        logic [NUM_CNT-1:0] r;
        for (int i = 0; i < NUM_CNT; i++) r[i] = (refCnt[i] > MAXV);
        return r;
    endfunction

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        zeroModel();
    endtask

    // Start cycle: whatever is on retire/event_vld/halt here must not count.
    task automatic startRun(input bit r, input logic [NUM_EVENTS-1:0] ev, input bit h);
        start = 1'b1; retire = r; event_vld = ev; halt = h;
        tick();
        start = 1'b0; retire = 1'b0; event_vld = '0; halt = 1'b0;
    endtask

    task automatic countCycle(input bit r, input logic [NUM_EVENTS-1:0] ev, input bit h);
        retire = r; event_vld = ev; halt = h;
        tick();
        refCnt[0]++;
        if (r) refCnt[1]++;
        for (int k = 0; k < NUM_EVENTS; k++) if (ev[k]) refCnt[2 + k]++;
        retire = 1'b0; event_vld = '0; halt = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready 1,0,0,1 then high; 2: random ready
    task automatic runDump(input string tag, input int mode);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int word = 0;
        int cyc  = 0;
        bit r;
        while (word < NUM_CNT && cyc < 200) begin
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc < 4) ? pat[cyc] : 1'b1;
            else                r = 1'($urandom_range(0, 1));
            dump_ready = r;
            check({tag, "_valid"}, 64'(dump_valid), 64'(1));
            check({tag, "_idx"},   64'(dump_idx),   64'(word));
            check({tag, "_data"},  64'(dump_data),  64'(expData(word)));
            check({tag, "_last"},  64'(dump_last),  64'(word == NUM_CNT - 1));
            tick();
            cyc++;
            if (r) word++;
        end
        dump_ready = 1'b0;
        check({tag, "_words"}, 64'(word), 64'(NUM_CNT));
        check({tag, "_cycles"}, 64'(cyc), 64'(mode == 0 ? NUM_CNT : cyc));
        check({tag, "_valid_after"}, 64'(dump_valid), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_ovf"},  64'(ovf),  64'(expOvf()));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0; retire = 1'b0; halt = 1'b0;
        event_vld = '0; dump_ready = 1'b0;
        zeroModel();

        // Reset values
        #3;
        check("rst_valid", 64'(dump_valid), 64'(0));
        check("rst_idx",   64'(dump_idx),   64'(0));
        check("rst_data",  64'(dump_data),  64'(0));
        check("rst_last",  64'(dump_last),  64'(0));
        check("rst_ovf",   64'(ovf),        64'(0));
        check("rst_busy",  64'(busy),       64'(0));
        check("rst_done",  64'(done),       64'(0));
        #9 rst = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'(0));

        // Basic count; start cycle carries strobes that must be ignored
        startRun(1'b1, 4'hF, 1'b0);
        check("start_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 10; i++) countCycle(i < 6, (i < 3) ? 4'b0011 : 4'b0000, 1'b0);
        check("count_no_valid", 64'(dump_valid), 64'(0));
        countCycle(1'b1, 4'b0000, 1'b1);
        check("basic_cycles_model", 64'(refCnt[0]), 64'(11));
        runDump("basic", 0);

        // Backpressure with ready 1,0,0,1
        doClear();
        check("clr_done", 64'(done), 64'(0));
        startRun(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 7; i++) countCycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
        countCycle(1'b0, 4'b1000, 1'b1);
        runDump("bp", 1);

        // Randomized runs with random backpressure
        for (int run = 0; run < 6; run++) begin
            int len;
            doClear();
            len = int'($urandom_range(0, 40));
            startRun(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
            for (int i = 0; i < len; i++)
                countCycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
            countCycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
            runDump("rand", 2);
        end

        // Saturation: ev0 held 300 cycles (the cycle counter saturates too)
        doClear();
        startRun(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 300; i++) countCycle(1'b0, 4'b0001, 1'b0);
        countCycle(1'b0, 4'b0000, 1'b1);
        check("sat_ovf_ev0", 64'(ovf[2]), 64'(1));
        runDump("sat", 0);
        doClear();
        check("sat_ovf_cleared", 64'(ovf), 64'(0));

        // Clear together with halt in COUNT
        startRun(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) countCycle(1'b1, 4'hF, 1'b0);
        clear = 1'b1; halt = 1'b1;
        tick();
        clear = 1'b0; halt = 1'b0;
        zeroModel();
        check("clrhalt_busy",  64'(busy),       64'(0));
        check("clrhalt_valid", 64'(dump_valid), 64'(0));
        check("clrhalt_ovf",   64'(ovf),        64'(0));
        tick();
        tick();
        check("clrhalt_valid_later", 64'(dump_valid), 64'(0));
        startRun(1'b0, 4'h0, 1'b0);
        countCycle(1'b0, 4'h0, 1'b1);
        runDump("clrhalt", 0);

        // start + halt together in IDLE: count only, no dump
        doClear();
        startRun(1'b1, 4'h5, 1'b1);
        check("sh_busy",  64'(busy),       64'(1));
        check("sh_valid", 64'(dump_valid), 64'(0));
        countCycle(1'b1, 4'h2, 1'b0);
        countCycle(1'b0, 4'h0, 1'b0);
        check("sh_valid_later", 64'(dump_valid), 64'(0));
        countCycle(1'b1, 4'h4, 1'b1);
        runDump("sh", 0);

        // Asynchronous reset mid-dump
        doClear();
        startRun(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) countCycle(1'b1, 4'hF, 1'b0);
        countCycle(1'b0, 4'h0, 1'b1);
        dump_ready = 1'b1;
        tick();
        dump_ready = 1'b0;
        check("ar_pre_idx", 64'(dump_idx), 64'(1));
        #3 rst = 1'b0;
        #1;
        check("ar_valid", 64'(dump_valid), 64'(0));
        check("ar_idx",   64'(dump_idx),   64'(0));
        check("ar_data",  64'(dump_data),  64'(0));
        check("ar_last",  64'(dump_last),  64'(0));
        check("ar_ovf",   64'(ovf),        64'(0));
        check("ar_busy",  64'(busy),       64'(0));
        check("ar_done",  64'(done),       64'(0));
        #2 rst = 1'b1;
        zeroModel();
        tick();
        startRun(1'b0, 4'h0, 1'b0);
        countCycle(1'b1, 4'h8, 1'b0);
        countCycle(1'b0, 4'h1, 1'b1);
        runDump("ar", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
